// File: rtl/div_pkg.sv
// div_pkg: shared FSM state type and width constants for seq_restoring_divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
    localparam int DVD_W_DEF = 8;
    localparam int DVS_W_DEF = 4;
    localparam int CNT_W_DEF = $clog2(DVD_W_DEF + 1);
    function automatic int cnt_w(input int dvd_w);
        return $clog2(dvd_w + 1);
    endfunction
endpackage

// File: rtl/div_datapath.sv
// div_datapath: operand, partial-remainder and quotient registers of the restoring divider.
// DIV_SIGNED_EN adds magnitude conversion on load and sign fixup on commit.
module div_datapath
    import div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic             zero,
    input  logic             step,
    input  logic             commit,
`ifdef DIV_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);
    // dvd shifts the dividend out of its top while quotient bits enter at the bottom
    logic [DVD_W-1:0] dvd, dvd_in, dvd_nxt, res_q;
    logic [DVS_W-1:0] dvs, dvs_in, pr, pr_nxt, res_r;
    logic [DVS_W:0]   pr_sh, diff;
    logic             ge;
    assign pr_sh   = {pr, dvd[DVD_W-1]};
    assign diff    = pr_sh - {1'b0, dvs};
    assign ge      = ~diff[DVS_W];
    assign pr_nxt  = ge ? diff[DVS_W-1:0] : pr_sh[DVS_W-1:0];
    assign dvd_nxt = {dvd[DVD_W-2:0], ge};
`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;
    assign dvd_in = (signed_mode && dividend[DVD_W-1]) ? -dividend : dividend;
    assign dvs_in = (signed_mode && divisor[DVS_W-1]) ? -divisor : divisor;
    assign res_q  = neg_q ? -dvd : dvd;
    assign res_r  = neg_r ? -pr : pr;
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            neg_q <= signed_mode & (dividend[DVD_W-1] ^ divisor[DVS_W-1]);
            neg_r <= signed_mode & dividend[DVD_W-1];
        end
`else
    assign dvd_in = dividend;
    assign dvs_in = divisor;
    assign res_q  = dvd_nxt;
    assign res_r  = pr_nxt;
`endif
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            dvd         <= '0;
            dvs         <= '0;
            pr          <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (load) begin
                dvd <= dvd_in;
                dvs <= dvs_in;
                pr  <= '0;
            end else if (step) begin
                dvd <= dvd_nxt;
                pr  <= pr_nxt;
            end
            if (zero) begin
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
            end else if (commit) begin
                quotient    <= res_q;
                remainder   <= res_r;
                div_by_zero <= 1'b0;
            end
        end
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: one-quotient-bit-per-clock restoring divider; FSM and step counter.
// Define DIV_SIGNED_EN for the signed_mode input and the extra FIXUP cycle.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = cnt_w(DVD_W);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load, zero, step, last, commit;
    assign last = cnt == CNT_W'(1);
    assign load = state == IDLE && start && divisor != '0;
    assign zero = state == IDLE && start && divisor == '0;
    assign step = state == CALC;
`ifdef DIV_SIGNED_EN
    assign commit = state == FIXUP;
`else
    assign commit = step && last;
`endif
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    state <= CALC;
                    cnt   <= CNT_W'(DVD_W);
                    busy  <= 1'b1;
                end else if (zero) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last) begin
`ifdef DIV_SIGNED_EN
                        state <= FIXUP;
`else
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                FIXUP: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
`endif
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    div_datapath #(.DVD_W(DVD_W), .DVS_W(DVS_W)) u_dp (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .load(load),
        .zero(zero),
        .step(step),
        .commit(commit),
`ifdef DIV_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .dividend(dividend),
        .divisor(divisor),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );
endmodule
